// File: rtl/id_stage.sv
// id_stage: MIPS decode stage (regfile, branch/jump resolve, hazard stall, ID/EX register); `ID_MEM_FWD_EN enables MEM->decode forwarding
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_pc,
  input  logic [31:0] ID_instr,
  input  logic        WB_we,
  input  logic [4:0]  WB_dst,
  input  logic [31:0] WB_data,
  input  logic [4:0]  EX_dst,
  input  logic        EX_load,
  input  logic [4:0]  MEM_dst,
  input  logic        MEM_load,
  input  logic [31:0] MEM_data,
  output logic        ID_stall,
  output logic [2:0]  ID_j,
  output logic [31:0] ID_npc,
  output logic [31:0] ID_pc_EX,
  output logic [31:0] ID_instr_EX,
  output logic [31:0] ID_rs_EX,
  output logic [31:0] ID_rt_EX,
  output logic [31:0] ID_ext_EX,
  output logic [4:0]  ID_dst_EX
);
  logic [31:0] rf [32];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, dst;
  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic use_rs, use_rt, cmp_rs, cmp_rt;
  logic ex_rs, ex_rt, mb_rs, mb_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic [31:0] sext, ext, pc4, rs_val, rt_val;
  assign op = ID_instr[31:26];
  assign fn = ID_instr[5:0];
  assign rs = ID_instr[25:21];
  assign rt = ID_instr[20:16];
  assign rd = ID_instr[15:11];
  assign is_r    = op == 6'h00;
  assign is_addu = is_r && fn == 6'h21;
  assign is_subu = is_r && fn == 6'h23;
  assign is_jr   = is_r && fn == 6'h08;
  assign is_ori  = op == 6'h0d;
  assign is_lui  = op == 6'h0f;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2b;
  assign is_beq  = op == 6'h04;
  assign is_j    = op == 6'h02;
  assign is_jal  = op == 6'h03;
  assign use_rs = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq | is_jr;
  assign use_rt = is_addu | is_subu | is_sw | is_beq;
  assign cmp_rs = is_beq | is_jr;
  assign cmp_rt = is_beq;
  assign dst = (is_addu | is_subu) ? rd : (is_ori | is_lui | is_lw) ? rt : is_jal ? 5'd31 : 5'd0;
  assign sext = {{16{ID_instr[15]}}, ID_instr[15:0]};
  assign pc4  = ID_pc + 32'd4;
  assign ext  = is_lui ? {ID_instr[15:0], 16'h0} : is_ori ? {16'h0, ID_instr[15:0]} : is_jal ? ID_pc + 32'd8 : sext;
  assign ex_rs = rs != 5'd0 && rs == EX_dst;
  assign ex_rt = rt != 5'd0 && rt == EX_dst;
  assign wb_rs = WB_we && WB_dst == rs;
  assign wb_rt = WB_we && WB_dst == rt;
`ifdef ID_MEM_FWD_EN
  assign mem_rs = rs != 5'd0 && rs == MEM_dst && !MEM_load;
  assign mem_rt = rt != 5'd0 && rt == MEM_dst && !MEM_load;
  assign mb_rs  = rs != 5'd0 && rs == MEM_dst && MEM_load;
  assign mb_rt  = rt != 5'd0 && rt == MEM_dst && MEM_load;
`else
  logic mem_unused;
  assign mem_unused = ^{MEM_data, MEM_load};
  assign mem_rs = 1'b0;
  assign mem_rt = 1'b0;
  assign mb_rs  = rs != 5'd0 && rs == MEM_dst;
  assign mb_rt  = rt != 5'd0 && rt == MEM_dst;
`endif
  assign rs_val = rs == 5'd0 ? 32'h0 : mem_rs ? MEM_data : wb_rs ? WB_data : rf[rs];
  assign rt_val = rt == 5'd0 ? 32'h0 : mem_rt ? MEM_data : wb_rt ? WB_data : rf[rt];
  assign ID_stall = (EX_load && ((use_rs && ex_rs) || (use_rt && ex_rt)))
                 || (cmp_rs && (ex_rs || mb_rs)) || (cmp_rt && (ex_rt || mb_rt));
  assign ID_j = ID_stall ? 3'd0 : (is_beq && rs_val == rt_val) ? 3'd1 : (is_j | is_jal) ? 3'd2 : is_jr ? 3'd3 : 3'd0;
  assign ID_npc = is_jr ? rs_val : (is_j | is_jal) ? {pc4[31:28], ID_instr[25:0], 2'b00} : pc4 + {sext[29:0], 2'b00};
  // register file: cleared on reset, $0 never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (WB_we && WB_dst != 5'd0) begin
      rf[WB_dst] <= WB_data;
    end
  end
  // decode/execute register: bubble on stall keeps only the pc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_pc_EX    <= RESET_PC;
      ID_instr_EX <= 32'h0;
      ID_rs_EX    <= 32'h0;
      ID_rt_EX    <= 32'h0;
      ID_ext_EX   <= 32'h0;
      ID_dst_EX   <= 5'd0;
    end else begin
      ID_pc_EX    <= ID_pc;
      ID_instr_EX <= ID_stall ? 32'h0 : ID_instr;
      ID_rs_EX    <= ID_stall ? 32'h0 : rs_val;
      ID_rt_EX    <= ID_stall ? 32'h0 : rt_val;
      ID_ext_EX   <= ID_stall ? 32'h0 : ext;
      ID_dst_EX   <= ID_stall ? 5'd0 : dst;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a mnemonic-level reference model
module tb_id_stage;
  logic clk = 0, rst = 1;
  logic [31:0] ID_pc = 0, ID_instr = 0, WB_data = 0, MEM_data = 0;
  logic WB_we = 0, EX_load = 0, MEM_load = 0;
  logic [4:0] WB_dst = 0, EX_dst = 0, MEM_dst = 0;
  logic ID_stall;
  logic [2:0] ID_j;
  logic [31:0] ID_npc, ID_pc_EX, ID_instr_EX, ID_rs_EX, ID_rt_EX, ID_ext_EX;
  logic [4:0] ID_dst_EX;
  logic [31:0] m_rf [32];
  int checks = 0, errors = 0;
`ifdef ID_MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_stage dut (
    .clk(clk), .rst(rst), .ID_pc(ID_pc), .ID_instr(ID_instr),
    .WB_we(WB_we), .WB_dst(WB_dst), .WB_data(WB_data),
    .EX_dst(EX_dst), .EX_load(EX_load), .MEM_dst(MEM_dst), .MEM_load(MEM_load), .MEM_data(MEM_data),
    .ID_stall(ID_stall), .ID_j(ID_j), .ID_npc(ID_npc),
    .ID_pc_EX(ID_pc_EX), .ID_instr_EX(ID_instr_EX), .ID_rs_EX(ID_rs_EX), .ID_rt_EX(ID_rt_EX),
    .ID_ext_EX(ID_ext_EX), .ID_dst_EX(ID_dst_EX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] s, t, d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] imm);
    return {o, s, t, imm};
  endfunction

  function automatic string mn(input logic [31:0] x);
    if (x[31:26] == 6'h00) begin
      if (x[5:0] == 6'h21) return "addu";
      if (x[5:0] == 6'h23) return "subu";
      if (x[5:0] == 6'h08) return "jr";
      return "nop";
    end
    if (x[31:26] == 6'h0d) return "ori";
    if (x[31:26] == 6'h0f) return "lui";
    if (x[31:26] == 6'h23) return "lw";
    if (x[31:26] == 6'h2b) return "sw";
    if (x[31:26] == 6'h04) return "beq";
    if (x[31:26] == 6'h02) return "j";
    if (x[31:26] == 6'h03) return "jal";
    return "nop";
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 0) return 0;
    if (FWD && r == MEM_dst && !MEM_load) return MEM_data;
    if (WB_we && WB_dst == r) return WB_data;
    return m_rf[r];
  endfunction

  function automatic bit ex_hit(input logic [4:0] r);
    return r != 0 && r == EX_dst;
  endfunction

  function automatic bit mem_hit(input logic [4:0] r);
    return r != 0 && r == MEM_dst && (FWD ? MEM_load : 1'b1);
  endfunction

  task automatic cyc(input string tag);
    string m;
    logic [4:0] s, t, d, e_dst;
    logic [31:0] a, b, sx, pc4, e_npc, e_ext;
    logic [2:0] e_j;
    bit us, ut, cs, ct, e_stall;
    #1;
    m = mn(ID_instr);
    s = ID_instr[25:21];
    t = ID_instr[20:16];
    d = ID_instr[15:11];
    a = opnd(s);
    b = opnd(t);
    sx = {{16{ID_instr[15]}}, ID_instr[15:0]};
    pc4 = ID_pc + 4;
    us = m == "addu" || m == "subu" || m == "ori" || m == "lw" || m == "sw" || m == "beq" || m == "jr";
    ut = m == "addu" || m == "subu" || m == "sw" || m == "beq";
    cs = m == "beq" || m == "jr";
    ct = m == "beq";
    e_dst = (m == "addu" || m == "subu") ? d : (m == "ori" || m == "lui" || m == "lw") ? t : (m == "jal") ? 5'd31 : 5'd0;
    e_ext = (m == "lui") ? {ID_instr[15:0], 16'h0} : (m == "ori") ? {16'h0, ID_instr[15:0]} : (m == "jal") ? ID_pc + 8 : sx;
    e_stall = (EX_load && ((us && ex_hit(s)) || (ut && ex_hit(t)))) || (cs && (ex_hit(s) || mem_hit(s))) || (ct && (ex_hit(t) || mem_hit(t)));
    e_j = 0;
    e_npc = 0;
    if (m == "beq") begin
      e_j = (a == b) ? 3'd1 : 3'd0;
      e_npc = pc4 + (sx << 2);
    end else if (m == "j" || m == "jal") begin
      e_j = 2;
      e_npc = {pc4[31:28], ID_instr[25:0], 2'b00};
    end else if (m == "jr") begin
      e_j = 3;
      e_npc = a;
    end
    if (e_stall) e_j = 0;
    chk({tag, ".stall"}, 32'(ID_stall), 32'(e_stall));
    chk({tag, ".j"}, 32'(ID_j), 32'(e_j));
    if (e_j != 0) chk({tag, ".npc"}, ID_npc, e_npc);
    @(posedge clk);
    if (WB_we && WB_dst != 0) m_rf[WB_dst] = WB_data;
    #1;
    chk({tag, ".pc_EX"}, ID_pc_EX, ID_pc);
    chk({tag, ".instr_EX"}, ID_instr_EX, e_stall ? 32'h0 : ID_instr);
    chk({tag, ".rs_EX"}, ID_rs_EX, e_stall ? 32'h0 : a);
    chk({tag, ".rt_EX"}, ID_rt_EX, e_stall ? 32'h0 : b);
    chk({tag, ".ext_EX"}, ID_ext_EX, e_stall ? 32'h0 : e_ext);
    chk({tag, ".dst_EX"}, 32'(ID_dst_EX), e_stall ? 32'h0 : 32'(e_dst));
  endtask

  task automatic idle();
    WB_we = 0; WB_dst = 0; WB_data = 0;
    EX_dst = 0; EX_load = 0;
    MEM_dst = 0; MEM_load = 0; MEM_data = 0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0] s, t, d;
    logic [15:0] imm;
    s = 5'($urandom_range(0, 7));
    t = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    imm = 16'($urandom());
    case ($urandom_range(0, 10))
      0: return enc_r(s, t, d, 6'h21);
      1: return enc_r(s, t, d, 6'h23);
      2: return enc_i(6'h0d, s, t, imm);
      3: return enc_i(6'h0f, s, t, imm);
      4: return enc_i(6'h23, s, t, imm);
      5: return enc_i(6'h2b, s, t, imm);
      6: return enc_i(6'h04, s, t, imm);
      7: return {6'h02, 26'($urandom())};
      8: return {6'h03, 26'($urandom())};
      9: return enc_r(s, 5'd0, 5'd0, 6'h08);
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc_EX", ID_pc_EX, 32'h3000);
    chk("rst.instr_EX", ID_instr_EX, 0);
    chk("rst.rs_EX", ID_rs_EX, 0);
    chk("rst.rt_EX", ID_rt_EX, 0);
    chk("rst.ext_EX", ID_ext_EX, 0);
    chk("rst.dst_EX", 32'(ID_dst_EX), 0);
    rst = 0;
    ID_pc = 32'h3000;
    ID_instr = enc_r(5'd5, 5'd0, 5'd9, 6'h21);
    cyc("rd5");
    chk("rd5.val", ID_rs_EX, 0);
    WB_we = 1; WB_dst = 0; WB_data = 32'hFFFF_FFFF;
    ID_instr = enc_r(5'd0, 5'd0, 5'd9, 6'h21);
    cyc("wb0");
    idle();
    cyc("rd0");
    chk("rd0.val", ID_rs_EX, 0);
    WB_we = 1; WB_dst = 8; WB_data = 32'h1234;
    ID_instr = enc_r(5'd8, 5'd0, 5'd9, 6'h21);
    cyc("bypass");
    chk("bypass.rs", ID_rs_EX, 32'h1234);
    chk("bypass.dst", 32'(ID_dst_EX), 9);
    idle();
    EX_load = 1; EX_dst = 8;
    ID_instr = enc_r(5'd8, 5'd8, 5'd9, 6'h21);
    #1;
    chk("loaduse.stall", 32'(ID_stall), 1);
    cyc("loaduse");
    chk("loaduse.bubble", ID_instr_EX, 0);
    EX_load = 0;
    cyc("loaduse2");
    chk("loaduse2.rs", ID_rs_EX, 32'h1234);
    idle();
    ID_instr = 0;
    WB_we = 1; WB_dst = 1; WB_data = 7;
    cyc("set1");
    WB_dst = 2;
    cyc("set2");
    idle();
    ID_pc = 32'h3010;
    ID_instr = enc_i(6'h04, 5'd1, 5'd2, 16'd4);
    #1;
    chk("beq.j", 32'(ID_j), 1);
    chk("beq.npc", ID_npc, 32'h3024);
    cyc("beq");
    WB_we = 1; WB_dst = 2; WB_data = 8;
    ID_instr = 0;
    cyc("set2b");
    idle();
    ID_instr = enc_i(6'h04, 5'd1, 5'd2, 16'd4);
    #1;
    chk("beqnt.j", 32'(ID_j), 0);
    cyc("beqnt");
    ID_pc = 32'h3000;
    ID_instr = {6'h03, 26'h000C10};
    #1;
    chk("jal.j", 32'(ID_j), 2);
    chk("jal.npc", ID_npc, 32'h3040);
    cyc("jal");
    chk("jal.dst", 32'(ID_dst_EX), 31);
    chk("jal.ext", ID_ext_EX, 32'h3008);
    MEM_dst = 31; MEM_data = 32'h3100; MEM_load = 0;
    ID_instr = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
    #1;
`ifdef ID_MEM_FWD_EN
    chk("jrfwd.j", 32'(ID_j), 3);
    chk("jrfwd.npc", ID_npc, 32'h3100);
    chk("jrfwd.stall", 32'(ID_stall), 0);
`else
    chk("jrnofwd.stall", 32'(ID_stall), 1);
`endif
    cyc("jr");
    idle();
    EX_load = 1; EX_dst = 8;
    ID_instr = enc_r(5'd8, 5'd8, 5'd9, 6'h21);
    #1;
    chk("midrst.stall", 32'(ID_stall), 1);
    #2 rst = 1;
    #1;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    chk("midrst.pc_EX", ID_pc_EX, 32'h3000);
    chk("midrst.instr_EX", ID_instr_EX, 0);
    chk("midrst.dst_EX", 32'(ID_dst_EX), 0);
    #1 rst = 0;
    idle();
    cyc("postrst");
    chk("postrst.rs8", ID_rs_EX, 0);
    for (int n = 0; n < 400; n++) begin
      ID_pc = $urandom() & 32'hFFFF_FFFC;
      ID_instr = rnd_instr();
      WB_we = 1'($urandom());
      WB_dst = 5'($urandom_range(0, 7));
      WB_data = $urandom_range(0, 3);
      EX_dst = 5'($urandom_range(0, 15));
      EX_load = 1'($urandom());
      MEM_dst = 5'($urandom_range(0, 15));
      MEM_load = 1'($urandom());
      MEM_data = $urandom_range(0, 3);
      cyc("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage MIPS pipeline. It sits directly downstream of the fetch stage and consumes the fetch/decode pipeline register (PC and instruction). It owns the 32×32 register file and resolves branches and jumps in decode, returning the jump select and target to fetch. It detects load-use and branch-operand hazards and asserts stall, and registers the decoded operands into the decode/execute pipeline register, inserting a bubble on stall.

## Interface
Parameters:
- `RESET_PC`, 32'h3000, value loaded into `ID_pc_EX` on reset.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ID_pc` in 32: PC of the instruction in decode.
- `ID_instr` in 32: instruction in decode.
- `WB_we` in 1: write-back enable.
- `WB_dst` in 5: write-back register.
- `WB_data` in 32: write-back value.
- `EX_dst` in 5: destination of the instruction in execute; 0 means none.
- `EX_load` in 1: the instruction in execute is `lw`.
- `MEM_dst` in 5: destination of the instruction in memory; 0 means none.
- `MEM_load` in 1: the instruction in memory is `lw`.
- `MEM_data` in 32: ALU/link result in memory.
- `ID_stall` out 1: freezes fetch and the fetch/decode register.
- `ID_j` out 3: next-PC select: 0 sequential, 1 beq taken, 2 j/jal, 3 jr.
- `ID_npc` out 32: redirect target, valid when `ID_j` is not 0.
- `ID_pc_EX`, `ID_instr_EX`, `ID_rs_EX`, `ID_rt_EX`, `ID_ext_EX` out 32 each: registered to execute.
- `ID_dst_EX` out 5: registered destination.

## Operation
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, and sll-0 as nop. Any other opcode is decoded as a nop with destination 0.
- Destination:
  - addu/subu: rd.
  - ori/lui/lw: rt.
  - jal: 31.
  - All others: 0.
- `ID_ext_EX`:
  - lui: {imm, 16'b0}.
  - ori: zero-extended imm.
  - jal: `ID_pc`+8.
  - All others: sign-extended imm.
- Register file:
  - $0 always reads 0.
  - Write occurs at the clock edge when `WB_we` is high and `WB_dst` is not 0.
  - Read is combinational. A read of `WB_dst` in the same cycle returns `WB_data` (bypass).
- Operand value, first match wins:
  1. `MEM_data`, if `MEM_dst` equals the address, is not 0, and `MEM_load` is 0.
  2. The WB bypass.
  3. The register file.
- Branch and jump targets:
  - beq: taken when the rs value equals the rt value; target = `ID_pc`+4+(sext(imm)<<2).
  - j/jal: target = {(`ID_pc`+4)[31:28], idx, 2'b00}.
  - jr: target = rs value.
  - The delay slot is always executed; fetch is never flushed.
- `ID_stall` is asserted when any of the following holds:
  - A source register the instruction actually uses equals `EX_dst` (not 0) and `EX_load` is 1.
  - The instruction is beq or jr and a compared register equals `EX_dst` (not 0).
  - The instruction is beq or jr, a compared register equals `MEM_dst` (not 0), and `MEM_load` is 1.
- While `ID_stall` is high, `ID_j` is 0.

## Timing
- `ID_stall`, `ID_j`, and `ID_npc` are combinational, in the same cycle as `ID_instr`.
- Decode/execute register, one-cycle latency:
  - Normal cycle: captures the decoded values at the clock edge.
  - Stall cycle: captures a bubble: `ID_instr_EX`=0, `ID_dst_EX`=0, `ID_rs_EX`=`ID_rt_EX`=`ID_ext_EX`=0, `ID_pc_EX`=`ID_pc`.
- Reset (asynchronous, takes effect immediately, including mid-stall):
  - All 32 registers are cleared.
  - `ID_pc_EX`=`RESET_PC`; all other registered outputs are 0.
- A register write and a read of the same register in the same cycle: the reader sees the new value.
- A write to $0 has no effect.
- Branch-in-delay-slot is not supported; behaviour is undefined.

## Configuration
- `ID_MEM_FWD_EN` defined:
  - MEM-stage forwarding into decode operands is enabled as described above.
- Not defined:
  - The MEM forwarding path is removed.
  - beq/jr also stall when a compared register equals `MEM_dst` (not 0), regardless of `MEM_load`.
  - Non-branch operands come from the register file or WB bypass only; execute resolves those hazards.

## Test plan
- Reset release: with `rst` high, `ID_pc_EX`=32'h3000, all other registered outputs 0, and a read of $5 returns 0. With `WB_we`=1, `WB_dst`=0, `WB_data`=FFFFFFFF for one cycle, a read of $0 returns 0.
- Bypass: `WB_we`=1, `WB_dst`=8, `WB_data`=1234 while decoding `addu $9,$8,$0` → the next `ID_rs_EX`=1234 and `ID_dst_EX`=9.
- Load-use: `EX_load`=1, `EX_dst`=8 with `addu $9,$8,$8` in decode → `ID_stall`=1 and the next edge registers a bubble. With `EX_load`=0 on the following cycle, the instruction issues normally.
- beq at `ID_pc`=3010 with imm=4 and $1=$2=7 → `ID_j`=1, `ID_npc`=3024. With $2=8 instead → `ID_j`=0.
- jal at `ID_pc`=3000 with idx=0x000C10 → `ID_j`=2, `ID_npc`=3040, `ID_dst_EX`=31, `ID_ext_EX`=3008.
- jr $31 with `MEM_dst`=31, `MEM_data`=3100, `MEM_load`=0:
  - With the macro: `ID_j`=3, `ID_npc`=3100, no stall.
  - Without the macro: `ID_stall`=1.
